// File: rtl/bus_pkg.sv
// Shared types and constants for the picorv32 native-bus fabric.
package bus_pkg;

  localparam int unsigned BUS_DW = 32;
  localparam int unsigned BUS_SW = 4;
  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    StIdle,
    StAccess,
    StErr,
    StResp,
    StTurn
  } bus_state_e;

endpackage

// File: rtl/bus_addr_decode.sv
// Combinational priority address decoder: lowest-index matching selector wins.
module bus_addr_decode
  import bus_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 6,
  parameter int unsigned DEC_BITS   = 4,
  parameter int unsigned SEL_W      = 3
) (
  input  logic [DEC_BITS-1:0]            field,
  input  logic [NUM_SLAVES*DEC_BITS-1:0] slave_sel,
  output logic                           hit,
  output logic [SEL_W-1:0]               sel
);

  // Scan from the top down so a lower index overrides any higher match.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int i = int'(NUM_SLAVES) - 1; i >= 0; i--) begin
      if (slave_sel[i*DEC_BITS +: DEC_BITS] == field) begin
        hit = 1'b1;
        sel = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/mem_bus_fabric.sv
// One-master, NUM_SLAVES-slave picorv32 native-bus interconnect with
// registered request/response, miss/timeout termination and fault logging.
module mem_bus_fabric
  import bus_pkg::*;
#(
  parameter int unsigned                     NUM_SLAVES = 6,
  parameter int unsigned                     DEC_LSB    = 12,
  parameter int unsigned                     DEC_BITS   = 4,
  parameter logic [NUM_SLAVES*DEC_BITS-1:0]  SLAVE_SEL  = 24'h54_3210,
  parameter int unsigned                     TIMEOUT    = 255,
  parameter logic [BUS_DW-1:0]               ERR_DATA   = ERR_DATA_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         m_valid,
  output logic                         m_ready,
  input  logic [BUS_DW-1:0]            m_addr,
  input  logic [BUS_DW-1:0]            m_wdata,
  input  logic [BUS_SW-1:0]            m_wstrb,
  output logic [BUS_DW-1:0]            m_rdata,
  output logic [NUM_SLAVES-1:0]        s_valid,
  output logic [BUS_DW-1:0]            s_addr,
  output logic [BUS_DW-1:0]            s_wdata,
  output logic [BUS_SW-1:0]            s_wstrb,
  input  logic [NUM_SLAVES-1:0]        s_ready,
  input  logic [NUM_SLAVES*BUS_DW-1:0] s_rdata,
  output logic                         bus_err,
  output logic [BUS_DW-1:0]            err_addr,
  output logic [7:0]                   err_count
);

  localparam int unsigned SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  bus_state_e          state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [BUS_DW-1:0]   addr_q, addr_d;
  logic [BUS_DW-1:0]   wdata_q, wdata_d;
  logic [BUS_SW-1:0]   wstrb_q, wstrb_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BUS_DW-1:0]   rdata_q, rdata_d;
  logic                bus_err_q, bus_err_d;
  logic [BUS_DW-1:0]   err_addr_q, err_addr_d;
  logic [7:0]          err_count_q, err_count_d;

  logic                dec_hit;
  logic [SEL_W-1:0]    dec_sel;
  logic                sel_ready;
  logic [BUS_DW-1:0]   sel_rdata;
  logic                fault;

  bus_addr_decode #(
    .NUM_SLAVES(NUM_SLAVES),
    .DEC_BITS  (DEC_BITS),
    .SEL_W     (SEL_W)
  ) u_decode (
    .field    (m_addr[DEC_LSB +: DEC_BITS]),
    .slave_sel(SLAVE_SEL),
    .hit      (dec_hit),
    .sel      (dec_sel)
  );

  assign sel_ready = s_ready[sel_q];
  assign sel_rdata = s_rdata[BUS_DW*sel_q +: BUS_DW];

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    bus_err_d   = 1'b0;
    err_addr_d  = err_addr_q;
    err_count_d = err_count_q;
    fault       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (m_valid) begin
          addr_d  = m_addr;
          wdata_d = m_wdata;
          wstrb_d = m_wstrb;
          sel_d   = dec_sel;
          cnt_d   = '0;
          state_d = dec_hit ? StAccess : StErr;
        end
      end
      StAccess: begin
        // A ready arriving on the timeout cycle still completes normally.
        if (sel_ready) begin
          rdata_d = sel_rdata;
          state_d = StResp;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          fault   = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StErr: begin
        fault   = 1'b1;
        state_d = StResp;
      end
      StResp:  state_d = StTurn;
      StTurn:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (fault) begin
      rdata_d    = ERR_DATA;
      bus_err_d  = 1'b1;
      err_addr_d = addr_q;
      if (err_count_q != 8'hFF) begin
        err_count_d = err_count_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      sel_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      cnt_q       <= '0;
      rdata_q     <= '0;
      bus_err_q   <= 1'b0;
      err_addr_q  <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      bus_err_q   <= bus_err_d;
      err_addr_q  <= err_addr_d;
      err_count_q <= err_count_d;
    end
  end

  // Handshake outputs derive only from registered state, so reset clears them at once.
  assign s_valid   = (state_q == StAccess) ? (NUM_SLAVES'(1) << sel_q) : '0;
  assign s_wstrb   = (state_q == StAccess) ? wstrb_q : '0;
  assign m_ready   = (state_q == StResp);
  assign s_addr    = addr_q;
  assign s_wdata   = wdata_q;
  assign m_rdata   = rdata_q;
  assign bus_err   = bus_err_q;
  assign err_addr  = err_addr_q;
  assign err_count = err_count_q;

endmodule
